// File: rtl/if_id_hazard_ctrl.sv
// Front-end pipeline sequencing controller for the 5-stage MIPS core.
//   Purpose:      drives PC enable and branch select, the IF/ID stall/flush/clear
//                 controls and the ID/EX bubble. Inputs are load-use hazards, EX
//                 branches, ID jumps and instruction-memory wait states.
//   Latency:      control outputs are combinational (Mealy) from state and inputs.
//                 State, flush counter, performance counters and watchdog update
//                 on the rising edge of clk.
//   Backpressure: imem_ready=0 freezes the PC and IF/ID (MEM_WAIT). A taken branch
//                 overrides any pending fetch wait.
// Ports:
//   clk, reset (async, active-high)
//   id_ex_mem_read, id_ex_rt, if_id_rs, if_id_rt  load-use detection
//   ex_branch_taken, id_jump, imem_ready           redirect / wait sources
//   pc_en, pc_sel_branch, if_id_stall, if_id_flush, if_id_clear, id_ex_bubble
//   ctrl_state                                     current FSM state
//   stall_cycles, flush_events                     wrapping 32-bit perf counters
//   stall_timeout                                  sticky watchdog flag
// Optional feature: define STALL_WATCHDOG_EN to build the consecutive-stall
// watchdog. Without it, stall_timeout is tied to 0.
module if_id_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 1,   // 1..4
  parameter int MAX_STALL    = 16   // 2..255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_ex_mem_read,
  input  logic [4:0]  id_ex_rt,
  input  logic [4:0]  if_id_rs,
  input  logic [4:0]  if_id_rt,
  input  logic        ex_branch_taken,
  input  logic        id_jump,
  input  logic        imem_ready,
  output logic        pc_en,
  output logic        pc_sel_branch,
  output logic        if_id_stall,
  output logic        if_id_flush,
  output logic        if_id_clear,
  output logic        id_ex_bubble,
  output logic [1:0]  ctrl_state,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_events,
  output logic        stall_timeout
);

  typedef enum logic [1:0] {
    RUN        = 2'b00,
    LOAD_STALL = 2'b01,
    MEM_WAIT   = 2'b10,
    REDIRECT   = 2'b11
  } state_t;

  // Flush cycles remaining after the branch cycle itself.
  localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);
  localparam state_t     BRANCH_NEXT  = (FLUSH_CYCLES > 1) ? REDIRECT : RUN;

  state_t     state, state_nxt;
  logic [2:0] flush_cnt, flush_cnt_nxt;
  logic       load_use;

  assign load_use = id_ex_mem_read && (id_ex_rt != 5'd0) &&
                    ((id_ex_rt == if_id_rs) || (id_ex_rt == if_id_rt));

  assign ctrl_state = state;

  always_comb begin
    pc_en         = 1'b1;
    pc_sel_branch = 1'b0;
    if_id_stall   = 1'b0;
    if_id_flush   = 1'b0;
    if_id_clear   = 1'b0;
    id_ex_bubble  = 1'b0;
    state_nxt     = state;
    flush_cnt_nxt = flush_cnt;

    case (state)
      RUN, LOAD_STALL, MEM_WAIT: begin
        if (ex_branch_taken) begin
          // Redirect wins over everything, including an outstanding fetch.
          pc_sel_branch = 1'b1;
          if_id_flush   = 1'b1;
          id_ex_bubble  = 1'b1;
          flush_cnt_nxt = FLUSH_RELOAD;
          state_nxt     = BRANCH_NEXT;
        end else if (!imem_ready) begin
          pc_en       = 1'b0;
          if_id_stall = 1'b1;
          state_nxt   = MEM_WAIT;
        end else if (state == MEM_WAIT) begin
          // Release cycle: defaults only, hazards are seen next cycle.
          state_nxt = RUN;
        end else if (load_use && (state == RUN)) begin
          // Masked in LOAD_STALL so a load-use costs exactly one cycle.
          pc_en        = 1'b0;
          if_id_stall  = 1'b1;
          id_ex_bubble = 1'b1;
          state_nxt    = LOAD_STALL;
        end else begin
          if_id_clear = id_jump;
          state_nxt   = RUN;
        end
      end
      REDIRECT: begin
        if_id_flush = 1'b1;
        if (ex_branch_taken) begin
          pc_sel_branch = 1'b1;
          flush_cnt_nxt = FLUSH_RELOAD;
          state_nxt     = BRANCH_NEXT;
        end else begin
          flush_cnt_nxt = flush_cnt - 3'd1;
          if (flush_cnt <= 3'd1) begin
            state_nxt = RUN;
          end
        end
      end
      default: state_nxt = RUN;
    endcase

    // Hold the pipeline completely quiet while in reset.
    if (reset) begin
      pc_en         = 1'b0;
      pc_sel_branch = 1'b0;
      if_id_stall   = 1'b0;
      if_id_flush   = 1'b0;
      if_id_clear   = 1'b0;
      id_ex_bubble  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= RUN;
      flush_cnt    <= 3'd0;
      stall_cycles <= 32'd0;
      flush_events <= 32'd0;
    end else begin
      state        <= state_nxt;
      flush_cnt    <= flush_cnt_nxt;
      stall_cycles <= stall_cycles + {31'd0, if_id_stall};
      flush_events <= flush_events + {31'd0, pc_sel_branch};
    end
  end

`ifdef STALL_WATCHDOG_EN
  localparam logic [7:0] STALL_LIMIT = 8'(MAX_STALL);

  logic [7:0] stall_run;
  logic       timeout_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_run <= 8'd0;
      timeout_q <= 1'b0;
    end else if (if_id_stall) begin
      if (stall_run != STALL_LIMIT) begin
        stall_run <= stall_run + 8'd1;
      end
      if (stall_run == STALL_LIMIT - 8'd1) begin
        timeout_q <= 1'b1;
      end
    end else begin
      stall_run <= 8'd0;
    end
  end

  assign stall_timeout = timeout_q;
`else
  assign stall_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_if_id_hazard_ctrl.sv
// Scoreboard bench for if_id_hazard_ctrl (FLUSH_CYCLES=2, MAX_STALL=16).
// Each cycle the stimulus pushes the expected controls, state, counters and
// watchdog flag. The record is popped and compared before the next clock edge.
module tb_if_id_hazard_ctrl;

  localparam int FC = 2;
  localparam int MS = 16;

  localparam logic [1:0] S_RUN = 2'b00, S_LS = 2'b01, S_MW = 2'b10, S_RD = 2'b11;

  // Control bit order: {pc_en, pc_sel_branch, if_id_stall, if_id_flush, if_id_clear, id_ex_bubble}
  localparam logic [5:0] C_DEF = 6'b100000;
  localparam logic [5:0] C_LU  = 6'b001001;
  localparam logic [5:0] C_MW  = 6'b001000;
  localparam logic [5:0] C_BR  = 6'b110101;
  localparam logic [5:0] C_RD  = 6'b100100;
  localparam logic [5:0] C_RDB = 6'b110100;
  localparam logic [5:0] C_JC  = 6'b100010;

  logic        clk, reset;
  logic        id_ex_mem_read, ex_branch_taken, id_jump, imem_ready;
  logic [4:0]  id_ex_rt, if_id_rs, if_id_rt;
  logic        pc_en, pc_sel_branch, if_id_stall, if_id_flush, if_id_clear, id_ex_bubble;
  logic [1:0]  ctrl_state;
  logic [31:0] stall_cycles, flush_events;
  logic        stall_timeout;

  if_id_hazard_ctrl #(.FLUSH_CYCLES(FC), .MAX_STALL(MS)) dut (
    .clk(clk), .reset(reset),
    .id_ex_mem_read(id_ex_mem_read), .id_ex_rt(id_ex_rt),
    .if_id_rs(if_id_rs), .if_id_rt(if_id_rt),
    .ex_branch_taken(ex_branch_taken), .id_jump(id_jump), .imem_ready(imem_ready),
    .pc_en(pc_en), .pc_sel_branch(pc_sel_branch), .if_id_stall(if_id_stall),
    .if_id_flush(if_id_flush), .if_id_clear(if_id_clear), .id_ex_bubble(id_ex_bubble),
    .ctrl_state(ctrl_state), .stall_cycles(stall_cycles), .flush_events(flush_events),
    .stall_timeout(stall_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [5:0]  ctl;
    logic [1:0]  st;
    logic [31:0] sc;
    logic [31:0] fe;
    logic        to;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference counters: stall/flush totals, consecutive stalls, sticky flag.
  logic [31:0] m_sc = 0, m_fe = 0;
  int          m_run = 0;
  logic        m_to = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_in(input logic mr, input logic [4:0] ert, input logic [4:0] rs,
                        input logic [4:0] rt, input logic br, input logic jmp,
                        input logic rdy);
    id_ex_mem_read  = mr;
    id_ex_rt        = ert;
    if_id_rs        = rs;
    if_id_rt        = rt;
    ex_branch_taken = br;
    id_jump         = jmp;
    imem_ready      = rdy;
  endtask

  task automatic neutral();
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
  endtask

  // Called about 1 time unit after a falling edge, with inputs already applied.
  task automatic step(input string tag, input logic [5:0] ctl, input logic [1:0] st);
    exp_t e;
    exp_t g;
    e.tag = tag; e.ctl = ctl; e.st = st;
    e.sc = m_sc; e.fe = m_fe;
`ifdef STALL_WATCHDOG_EN
    e.to = m_to;
`else
    e.to = 1'b0;
`endif
    exp_q.push_back(e);
    // Advance the reference model to its post-edge state.
    m_sc = m_sc + {31'd0, ctl[3]};
    m_fe = m_fe + {31'd0, ctl[4]};
    if (ctl[3]) begin
      if (m_run == MS - 1) m_to = 1'b1;
      if (m_run < MS) m_run++;
    end else begin
      m_run = 0;
    end
    #2;
    g = exp_q.pop_front();
    check({g.tag, ".ctl"}, {26'd0, pc_en, pc_sel_branch, if_id_stall, if_id_flush,
                            if_id_clear, id_ex_bubble}, {26'd0, g.ctl});
    check({g.tag, ".state"}, {30'd0, ctrl_state}, {30'd0, g.st});
    check({g.tag, ".stall_cycles"}, stall_cycles, g.sc);
    check({g.tag, ".flush_events"}, flush_events, g.fe);
    check({g.tag, ".timeout"}, {31'd0, stall_timeout}, {31'd0, g.to});
    @(negedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    check({tag, ".ctl"}, {26'd0, pc_en, pc_sel_branch, if_id_stall, if_id_flush,
                          if_id_clear, id_ex_bubble}, 32'd0);
    check({tag, ".state"}, {30'd0, ctrl_state}, {30'd0, S_RUN});
    check({tag, ".stall_cycles"}, stall_cycles, 32'd0);
    check({tag, ".flush_events"}, flush_events, 32'd0);
    check({tag, ".timeout"}, {31'd0, stall_timeout}, 32'd0);
    m_sc = 0; m_fe = 0; m_run = 0; m_to = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    neutral();
    @(negedge clk);
    #1;
    check_reset("reset");
    reset = 1'b0;

    // Load-use: exactly one stall cycle, then masked in LOAD_STALL.
    set_in(1'b1, 5'd8, 5'd8, 5'd3, 1'b0, 1'b0, 1'b1);
    step("lu0", C_LU, S_RUN);
    step("lu1", C_DEF, S_LS);
    neutral();
    step("lu2", C_DEF, S_RUN);
    // Match on the rt source operand.
    set_in(1'b1, 5'd9, 5'd1, 5'd9, 1'b0, 1'b0, 1'b1);
    step("lu_rt", C_LU, S_RUN);
    neutral();
    step("lu_rt1", C_DEF, S_LS);

    // Load into $0 never stalls.
    set_in(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    step("ld_r0", C_DEF, S_RUN);

    // Jump clears IF/ID.
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
    step("jump", C_JC, S_RUN);

    // Taken branch: two flush cycles, pc_sel_branch only in the first.
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1);
    step("br0", C_BR, S_RUN);
    neutral();
    step("br1", C_RD, S_RD);
    step("br2", C_DEF, S_RUN);

    // Branch wins over load-use and jump.
    set_in(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b1, 1'b1);
    step("prio0", C_BR, S_RUN);
    neutral();
    step("prio1", C_RD, S_RD);
    step("prio2", C_DEF, S_RUN);

    // Memory wait for three cycles, release on the fourth.
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    step("mw0", C_MW, S_RUN);
    step("mw1", C_MW, S_MW);
    step("mw2", C_MW, S_MW);
    neutral();
    step("mw3", C_DEF, S_MW);
    step("mw4", C_DEF, S_RUN);

    // Branch during MEM_WAIT abandons the fetch. REDIRECT ignores imem_ready.
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    step("bmw0", C_MW, S_RUN);
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    step("bmw1", C_BR, S_MW);
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    step("bmw2", C_RD, S_RD);
    neutral();
    step("bmw3", C_DEF, S_RUN);

    // Back-to-back branch reloads the flush counter in REDIRECT.
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1);
    step("bb0", C_BR, S_RUN);
    step("bb1", C_RDB, S_RD);
    neutral();
    step("bb2", C_RD, S_RD);
    step("bb3", C_DEF, S_RUN);

    // Long memory wait: 20 stall cycles exercise the watchdog.
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    step("wd_first", C_MW, S_RUN);
    for (int i = 1; i < 20; i++) step("wd", C_MW, S_MW);
    neutral();
    step("wd_rel", C_DEF, S_MW);
    step("wd_hold", C_DEF, S_RUN);
    step("wd_hold2", C_DEF, S_RUN);

    // Asynchronous reset in the middle of MEM_WAIT.
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    step("mr0", C_MW, S_RUN);
    step("mr1", C_MW, S_MW);
    reset = 1'b1;
    #1;
    check_reset("midreset");
    @(negedge clk);
    #1;
    reset = 1'b0;
    neutral();
    step("post_reset", C_DEF, S_RUN);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/if_id_hazard_ctrl.md
# if_id_hazard_ctrl

Pipeline sequencing controller for the front end of the 5-stage MIPS core. It drives the stall, flush and clear inputs of the IF/ID register, the PC write enable, and the ID/EX bubble. Decisions come from load-use hazards, taken branches resolved in EX, jumps decoded in ID, and instruction-memory wait states. A registered FSM sequences multi-cycle events; performance counters track stall and flush activity.

## Interface
- FLUSH_CYCLES, 1: cycles `if_id_flush` stays high per taken branch (1..4).
- MAX_STALL, 16: consecutive-stall threshold for the watchdog (2..255).
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- id_ex_mem_read  in  1  instruction in EX is a load.
- id_ex_rt  in  5  load destination register.
- if_id_rs, if_id_rt  in  5 each  source registers of the instruction in ID.
- ex_branch_taken  in  1  branch in EX resolved taken.
- id_jump  in  1  jump decoded in ID.
- imem_ready  in  1  instruction memory returns valid data this cycle.
- pc_en  out  1  PC write enable.
- pc_sel_branch  out  1  PC loads branch target this cycle.
- if_id_stall, if_id_flush, if_id_clear  out  1 each  IF/ID register controls.
- id_ex_bubble  out  1  insert a NOP into ID/EX.
- ctrl_state  out  2  current FSM state.
- stall_cycles, flush_events  out  32 each  performance counters.
- stall_timeout  out  1  sticky watchdog flag.

## Operation
- FSM states:
  - RUN=00
  - LOAD_STALL=01
  - MEM_WAIT=10
  - REDIRECT=11
- load_use = id_ex_mem_read && id_ex_rt!=0 && (id_ex_rt==if_id_rs || id_ex_rt==if_id_rt).
- Default outputs: pc_en=1; all other control outputs 0.
- RUN and LOAD_STALL evaluate in strict priority order. In LOAD_STALL, load_use is masked.
  1. ex_branch_taken: pc_sel_branch=1, if_id_flush=1, id_ex_bubble=1. Next state is REDIRECT if FLUSH_CYCLES>1, else RUN. Load the flush counter with FLUSH_CYCLES-1.
  2. !imem_ready: pc_en=0, if_id_stall=1; next MEM_WAIT.
  3. load_use: pc_en=0, if_id_stall=1, id_ex_bubble=1; next LOAD_STALL.
  4. id_jump: if_id_clear=1; next RUN.
  5. Otherwise: next RUN.
- MEM_WAIT:
  - ex_branch_taken: behaves as RUN item 1. The pending fetch is abandoned.
  - Else if !imem_ready: pc_en=0, if_id_stall=1; stay in MEM_WAIT.
  - Else: release with default outputs and go to RUN. Hazards are re-evaluated in the following cycle.
- REDIRECT:
  - if_id_flush=1; decrement the counter; go to RUN when the counter reaches 0.
  - A new ex_branch_taken during REDIRECT asserts pc_sel_branch and reloads the counter with FLUSH_CYCLES-1.
  - imem_ready is ignored in REDIRECT.
- if_id_flush and if_id_clear are never high in the same cycle. The priority order guarantees this.
- stall_cycles increments on every cycle with if_id_stall=1.
- flush_events increments once per cycle in which pc_sel_branch=1.
- Both counters wrap modulo 2^32.

## Timing
- State, flush counter, performance counters and watchdog are registered on the clk rising edge.
- All control outputs are combinational (Mealy) from state and inputs, with zero-cycle latency.
- A load-use hazard costs exactly 1 stall cycle.
- A taken branch flushes for FLUSH_CYCLES cycles, starting in the cycle ex_branch_taken is observed.
- While reset is high:
  - ctrl_state=RUN.
  - pc_en=0 and every other control output is 0.
  - Counters = 0, stall_timeout=0, flush counter=0.
- Reset asserted mid-operation aborts MEM_WAIT and REDIRECT immediately.
- After reset deasserts, the first edge evaluates from RUN.

## Configuration
- STALL_WATCHDOG_EN defined:
  - An 8-bit consecutive-stall counter increments while if_id_stall=1 and clears on any cycle with if_id_stall=0.
  - When the counter reaches MAX_STALL, stall_timeout sets and stays set until reset. The counter saturates.
  - The flag does not alter control outputs.
- STALL_WATCHDOG_EN undefined: no counter logic is built; stall_timeout is tied to 0.

## Test plan
- Load-use: id_ex_mem_read=1, id_ex_rt=8, if_id_rs=8 in RUN.
  - Cycle 0: pc_en=0, if_id_stall=1, id_ex_bubble=1, next LOAD_STALL.
  - Cycle 1 with the same inputs: no stall; back to RUN. stall_cycles=1.
- Load into $0: id_ex_rt=0, if_id_rs=0 -> no stall, pc_en=1.
- Taken branch with FLUSH_CYCLES=2: ex_branch_taken pulse.
  - if_id_flush high for 2 cycles; pc_sel_branch high for the first cycle only.
  - flush_events=1; FSM path RUN->REDIRECT->RUN.
- Memory wait: imem_ready=0 for 3 cycles, then 1.
  - if_id_stall and pc_en=0 for 3 cycles; ctrl_state=MEM_WAIT; release on the 4th cycle. stall_cycles=3.
- Branch during MEM_WAIT (imem_ready held 0): pc_sel_branch=1, if_id_flush=1, id_ex_bubble=1 in the same cycle; exit MEM_WAIT.
- Watchdog (macro on, MAX_STALL=16): imem_ready=0 for 20 cycles.
  - stall_timeout rises after the 16th stall cycle and stays high after imem_ready=1.
  - Clears only on reset. Macro off: stays 0.
